// File: rtl/sd_pio_pkg.sv
// sd_pio_pkg
//   Shared constants and helpers for the parametrised SD bidirectional PIO.
//   Holds the Avalon register word addresses, the edge-type encodings used
//   by the EDGE_TYPE parameter, and a zero-extension helper for building
//   32-bit read data from narrower register contents.
//   No ports (package).

package sd_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_DIR      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Clears every bit at or above position w, so a w-bit quantity carried
    // in a 32-bit container is returned cleanly zero-extended.
    function automatic logic [31:0] zext32(input logic [31:0] v, input int unsigned w);
        if (w >= 32)
            return v;
        return v & ((32'h1 << w) - 32'h1);
    endfunction

endpackage

// File: rtl/sd_pio_sync_edge.sv
// sd_pio_sync_edge
//   Input synchroniser and edge detector for the SD PIO pins.
//   Ports:
//     clk        in   system clock (rising edge)
//     reset_n    in   synchronous active-low reset
//     pin_in     in   raw pad values, WIDTH bits
//     sync_in    out  pad values after SYNC_STAGES flops
//     edge_pulse out  one-cycle pulse per bit on the edge chosen by EDGE_TYPE
//   sync_prev is one more flop behind sync_in; the edge is the difference
//   between the two, so a pulse lines up with the first cycle sync_in shows
//   the new level.

module sd_pio_sync_edge
    import sd_pio_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] sync_prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    // Synchroniser chain and history flop. Clearing sync_prev on reset means
    // the first cycle after release can only ever look like a rising edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_p[i] <= '0;
            sync_prev <= '0;
        end else begin
            sync_p[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_p[i] <= sync_p[i-1];
            sync_prev <= sync_p[SYNC_STAGES-1];
        end
    end

    assign sync_in = sync_p[SYNC_STAGES-1];
    assign rise    = sync_in & ~sync_prev;
    assign fall    = ~sync_in & sync_prev;

    generate
        if (EDGE_TYPE == EDGE_RISE) begin : g_rise
            assign edge_pulse = rise;
        end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign edge_pulse = fall;
        end else begin : g_any
            assign edge_pulse = rise | fall;
        end
    endgenerate

endmodule

// File: rtl/sd_bidir_pio.sv
// sd_bidir_pio
//   Avalon-MM slave controlling WIDTH bidirectional SD pad pins (CMD and
//   DAT lines) with per-bit direction, synchronised readback, edge capture
//   (write-1-to-clear) and a maskable level interrupt.
//   Ports:
//     clk         in    system clock (rising edge)
//     reset_n     in    synchronous active-low reset
//     address     in    register word address (3 bits)
//     chipselect  in    slave select
//     write_n     in    active-low write strobe
//     writedata   in    32-bit write data, bits >= WIDTH ignored
//     readdata    out   registered read data, 1-cycle latency, zero-extended
//     bidir_port  inout pad pins, driven from data_out where dir=1, else Z
//     irq         out   OR of (edge_capture & irq_mask), combinational
//   Build option: define SD_PIO_SETCLR_EN to add OUTSET (addr 4) and
//   OUTCLR (addr 5) atomic bit set/clear of data_out. Without it those
//   addresses read 0 and ignore writes.

module sd_bidir_pio
    import sd_pio_pkg::*;
#(
    parameter int          WIDTH       = 5,
    parameter logic [31:0] DIR_RESET   = 32'h0,
    parameter int          EDGE_TYPE   = 1,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    inout  wire  [WIDTH-1:0] bidir_port,
    output logic             irq
);

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] rd_sel;
    logic [31:0]      rd_next;
    logic             wr;

    assign wr    = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_unused_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = |writedata[31:WIDTH];
        end
    endgenerate

    sd_pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .reset_n    (reset_n),
        .pin_in     (bidir_port),
        .sync_in    (sync_in),
        .edge_pulse (edge_pulse)
    );

    // A clear-write only removes bits; the new edge is ORed in afterwards so
    // an edge arriving in the same cycle as its clear is not lost.
    assign cap_clr = (wr && address == ADDR_EDGE_CAP) ? wdata : '0;

    always_comb begin
        rd_sel = '0;
        case (address)
            ADDR_DATA:     rd_sel = sync_in;
            ADDR_DIR:      rd_sel = dir;
            ADDR_IRQ_MASK: rd_sel = irq_mask;
            ADDR_EDGE_CAP: rd_sel = edge_capture;
            default:       rd_sel = '0;
        endcase
        rd_next = zext32(32'(rd_sel), WIDTH);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out     <= '0;
            dir          <= DIR_RESET[WIDTH-1:0];
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
        end else begin
            readdata     <= rd_next;
            edge_capture <= (edge_capture & ~cap_clr) | edge_pulse;
            if (wr) begin
                case (address)
                    ADDR_DATA:     data_out <= wdata;
                    ADDR_DIR:      dir      <= wdata;
                    ADDR_IRQ_MASK: irq_mask <= wdata;
`ifdef SD_PIO_SETCLR_EN
                    ADDR_OUTSET:   data_out <= data_out | wdata;
                    ADDR_OUTCLR:   data_out <= data_out & ~wdata;
`endif
                    default: ;
                endcase
            end
        end
    end

    assign irq = |(edge_capture & irq_mask);

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_pad
            assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
        end
    endgenerate

endmodule

// File: tb/tb_sd_bidir_pio.sv
// tb_sd_bidir_pio
//   Self-checking bench for sd_bidir_pio. A cycle-level behavioural model of
//   the register file (pin sample history, register values, read mux) is
//   compared against readdata, irq and the resolved pad values every cycle,
//   alongside directed sequences with literal expectations and a randomised
//   phase. The bench drives each pad only where the expected direction is
//   input, so the resolved pad value is fully predictable.

module tb_sd_bidir_pio;
    import sd_pio_pkg::*;

    localparam int          W     = 5;
    localparam int          SYNC  = 2;
    localparam int          EDGE  = 1;
    localparam logic [31:0] DIRR  = 32'h0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    wire  [31:0] readdata;
    wire         irq;
    wire  [W-1:0] pins;

    logic [W-1:0] tb_val = '0;
    logic [W-1:0] tb_oe  = '1;

    always #5 clk = ~clk;

    for (genvar i = 0; i < W; i++) begin : g_drv
        assign pins[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    sd_bidir_pio #(
        .WIDTH       (W),
        .DIR_RESET   (DIRR),
        .EDGE_TYPE   (EDGE),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .bidir_port (pins),
        .irq        (irq)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_dout, m_dir, m_mask, m_cap;
    logic [31:0]  m_rd;
    logic         m_irq;
    logic         model_ok = 1'b0;
    logic [W-1:0] samp [0:SYNC];   // samp[0] = newest pad sample
    logic [W-1:0] pin_s;

    // Pads are stable from just after a posedge until the next one, so the
    // negedge value is what the design samples at the following posedge.
    initial forever begin
        @(negedge clk);
        pin_s = pins;
    end

    initial forever begin
        logic [W-1:0] sin, sprev, rise, fall, edg, clr, wd;
        logic         wr;
        @(posedge clk);
        sin   = samp[SYNC-1];
        sprev = samp[SYNC];
        if (!reset_n) begin
            m_dout = '0;
            m_dir  = DIRR[W-1:0];
            m_mask = '0;
            m_cap  = '0;
            m_rd   = 32'h0;
            for (int k = 0; k <= SYNC; k++)
                samp[k] = '0;
            model_ok = 1'b1;
        end else begin
            wr = chipselect && !write_n;
            wd = writedata[W-1:0];
            case (address)
                3'd0:    m_rd = 32'(sin);
                3'd1:    m_rd = 32'(m_dir);
                3'd2:    m_rd = 32'(m_mask);
                3'd3:    m_rd = 32'(m_cap);
                default: m_rd = 32'h0;
            endcase
            rise = sin & ~sprev;
            fall = sprev & ~sin;
            edg  = (EDGE == 0) ? rise : (EDGE == 1) ? fall : (rise | fall);
            clr  = (wr && address == 3'd3) ? wd : '0;
            m_cap = (m_cap & ~clr) | edg;
            if (wr) begin
                if (address == 3'd0) m_dout = wd;
                if (address == 3'd1) m_dir  = wd;
                if (address == 3'd2) m_mask = wd;
`ifdef SD_PIO_SETCLR_EN
                if (address == 3'd4) m_dout = m_dout | wd;
                if (address == 3'd5) m_dout = m_dout & ~wd;
`endif
            end
            for (int k = SYNC; k > 0; k--)
                samp[k] = samp[k-1];
            samp[0] = pin_s;
        end
        m_irq = |(m_cap & m_mask);
    end

    initial forever begin
        logic [W-1:0] exp_pins;
        @(negedge clk);
        if (model_ok) begin
            exp_pins = (m_dir & m_dout) | (~m_dir & tb_val);
            check("readdata", readdata, m_rd);
            check("irq", {31'b0, irq}, {31'b0, m_irq});
            check("pins", 32'(pins), 32'(exp_pins));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        if (a == ADDR_DIR)
            tb_oe = ~d[W-1:0];
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] v);
        address = a;
        step(1);
        v = readdata;
    endtask

    logic [31:0] v;
    logic        pend;
    logic        was_rst;
    logic [W-1:0] pend_val;

    initial begin
        // Reset and idle state
        step(3);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(3'(a), v);
            check($sformatf("reset_read_a%0d", a), v, 32'h0);
        end
        check("reset_irq", {31'b0, irq}, 32'h0);
        tb_val = 5'h0A;
        step(1);
        check("pins_z_after_reset", 32'(pins), 32'h0A);
        step(SYNC);
        bus_read(ADDR_DATA, v);
        check("data_reads_input", v, 32'h0A);

        // Output drive and readback latency
        bus_write(ADDR_DIR, 32'h1F);
        bus_write(ADDR_DATA, 32'hFFFF_FFF5);
        check("pins_drive_10101", 32'(pins), 32'h15);
        step(SYNC);
        bus_read(ADDR_DATA, v);
        check("data_readback_15", v, 32'h15);
        bus_read(ADDR_DIR, v);
        check("dir_readback", v, 32'h1F);

        // Falling edge capture on pin0, irq, and W1C
        tb_val = 5'h1F;
        bus_write(ADDR_DIR, 32'h0);
        bus_write(ADDR_IRQ_MASK, 32'h01);
        step(4);
        bus_write(ADDR_EDGE_CAP, 32'h1F);
        bus_read(ADDR_EDGE_CAP, v);
        check("cap_cleared", v, 32'h0);
        check("irq_idle", {31'b0, irq}, 32'h0);
        tb_val[0] = 1'b0;
        step(SYNC + 1);
        check("irq_on_fall", {31'b0, irq}, 32'h1);
        bus_read(ADDR_EDGE_CAP, v);
        check("cap_pin0", v, 32'h01);
        bus_write(ADDR_EDGE_CAP, 32'h01);
        check("irq_after_w1c", {31'b0, irq}, 32'h0);
        bus_read(ADDR_EDGE_CAP, v);
        check("cap_after_w1c", v, 32'h0);

        // Clear-write coinciding with a new edge on pin1: set wins
        tb_val[1] = 1'b0;
        step(SYNC);
        bus_write(ADDR_EDGE_CAP, 32'h02);
        bus_read(ADDR_EDGE_CAP, v);
        check("set_beats_clear", v, 32'h02);

        // OUTSET / OUTCLR
        bus_write(ADDR_DIR, 32'h1F);
        bus_write(ADDR_DATA, 32'h03);
        bus_write(ADDR_OUTSET, 32'h10);
        bus_write(ADDR_OUTCLR, 32'h01);
`ifdef SD_PIO_SETCLR_EN
        check("setclr_pins", 32'(pins), 32'h12);
`else
        check("setclr_pins", 32'(pins), 32'h03);
`endif
        bus_read(ADDR_OUTSET, v);
        check("outset_reads_0", v, 32'h0);
        step(SYNC);
        bus_read(ADDR_DATA, v);
`ifdef SD_PIO_SETCLR_EN
        check("setclr_readback", v, 32'h12);
`else
        check("setclr_readback", v, 32'h03);
`endif

        // Mid-operation reset
        bus_write(ADDR_IRQ_MASK, 32'h1F);
        bus_write(ADDR_DATA, 32'h0);
        step(SYNC + 1);
        check("irq_before_reset", {31'b0, irq}, 32'h1);
        tb_val  = 5'h1F;
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        tb_oe   = '1;
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq_mid", {31'b0, irq}, 32'h0);
        step(SYNC + 3);
        bus_read(ADDR_EDGE_CAP, v);
        check("no_edge_after_release", v, 32'h0);
        bus_read(ADDR_DIR, v);
        check("dir_after_reset", v, 32'h0);
        bus_read(ADDR_DATA, v);
        check("data_after_reset", v, 32'h1F);

        // Randomised traffic, checked every cycle against the model
        pend    = 1'b0;
        was_rst = 1'b0;
        repeat (1500) begin
            if (was_rst)
                tb_oe = '1;
            else if (pend)
                tb_oe = ~pend_val;
            pend = 1'b0;
            reset_n    = ($urandom_range(0, 199) != 0);
            address    = 3'($urandom_range(0, 7));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'($urandom_range(0, 1));
            writedata  = $urandom;
            if ($urandom_range(0, 2) == 0)
                tb_val = W'($urandom);
            if (chipselect && !write_n && address == ADDR_DIR && reset_n) begin
                pend     = 1'b1;
                pend_val = writedata[W-1:0];
            end
            was_rst = !reset_n;
            step(1);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset_n    = 1'b1;
        if (was_rst)
            tb_oe = '1;
        else if (pend)
            tb_oe = ~pend_val;
        step(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sd_bidir_pio.md
Name: sd_bidir_pio

Overview:
- Parametrised successor to the single-bit SD bidirectional PIO. Provides an Avalon-MM slave with WIDTH open bidirectional pins (SD CMD plus DAT[3:0] or a subset) and per-bit direction control.
- Adds input synchronisation, edge capture with write-1-to-clear and a maskable level interrupt, so firmware can detect card busy or start bits without polling.
- Sits between the Nios SD driver bus and the SD card pad ring.

Parameters:
- WIDTH, 5, number of bidirectional pins; legal range 1..32.
- DIR_RESET, 0, reset value of the direction register (1 = output).
- EDGE_TYPE, 1, edge that sets capture bits: 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2, input synchroniser depth; legal range 2..3.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- address  in  3  register word address.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  Avalon write strobe, active-low.
- writedata  in  32  write data; only [WIDTH-1:0] is used.
- readdata  out  32  registered read data, zero-extended above WIDTH.
- bidir_port  inout  WIDTH  pad pins. Bit i is driven with data_out[i] when dir[i]=1; otherwise it is Z.
- irq  out  1  level interrupt = OR of (edge_capture AND irq_mask).

Behaviour:
- Write occurs when chipselect=1 and write_n=0. The register is updated at the next clk edge.
- Register map:
  - 0 DATA: read returns the synchronised input; write sets data_out.
  - 1 DIR: R/W.
  - 2 IRQ_MASK: R/W.
  - 3 EDGE_CAP: read returns captured edges; writing 1 clears a bit.
  - 4 OUTSET, 5 OUTCLR: optional, see Optional Feature.
  - 6, 7: read as 0; writes are ignored.
- Read latency is 1 cycle.
  - readdata is updated every cycle from the address mux, regardless of chipselect.
  - Unimplemented bits read 0.
- Input path:
  - bidir_port passes through SYNC_STAGES flops to give sync_in.
  - A further flop gives sync_prev.
  - DATA reads sync_in, so a pin change is visible after SYNC_STAGES+1 cycles. An output bit reads back its own driven value after the same delay.
- Edge detect:
  - rise = sync_in & ~sync_prev; fall = ~sync_in & sync_prev.
  - The selected edge sets edge_capture[i] in the following cycle.
  - Edges are detected on output-mode bits as well.
- Simultaneous EDGE_CAP clear-write and a new edge on the same bit: the set wins and the bit stays 1.
- irq is combinational from the registers and has no extra delay after edge_capture or irq_mask changes.
- Reset values:
  - data_out=0, dir=DIR_RESET, irq_mask=0, edge_capture=0, readdata=0, irq=0.
  - The synchroniser chain and sync_prev reset to 0.
- Reset taken mid-operation clears all of the above on that edge. Pins with DIR_RESET=0 go to Z. No spurious edge is captured in the first cycle after reset release, because sync_prev=0 and the capture register is held cleared during reset.
- Bits at or above WIDTH in writedata are ignored.

Optional Feature:
- Macro: SD_PIO_SETCLR_EN.
- Defined:
  - Address 4 OUTSET does data_out |= writedata.
  - Address 5 OUTCLR does data_out &= ~writedata.
  - Both read as 0.
- Not defined: addresses 4 and 5 behave like 6 and 7 (read 0, writes ignored). No set/clear logic is synthesised.

Decomposition:
- Package sd_pio_pkg holds:
  - address constants ADDR_DATA..ADDR_OUTCLR;
  - edge-type constants EDGE_RISE, EDGE_FALL, EDGE_ANY;
  - a function that zero-extends a WIDTH-bit vector to 32 bits.
- One sub-module, sd_pio_sync_edge. Parameters: WIDTH, SYNC_STAGES, EDGE_TYPE. It contains the synchroniser chain, the sync_prev flop and the edge pulse output.
- The top level holds the register file, the capture register, the read mux and the tristates.

Test Plan:
- Reset, then read addresses 0..3 → readdata=0. All pins Z, irq=0.
- Write DIR=0x1F, then DATA=0x15 → pins show 10101. Reading DATA after SYNC_STAGES+1 cycles returns 0x15.
- DIR=0, IRQ_MASK=0x01, EDGE_TYPE=1; drive pin0 1→0:
  - EDGE_CAP reads 0x01 and irq=1.
  - Write EDGE_CAP=0x01 → reads 0 and irq=0.
- Drive a falling edge on pin1 in the same cycle as an EDGE_CAP write of 0x02 → bit1 remains 1.
- With SD_PIO_SETCLR_EN defined: DATA=0x03, OUTSET=0x10, then OUTCLR=0x01 → data_out=0x12.
  - Same sequence with the macro undefined → data_out stays 0x03.
- Assert reset_n=0 for one cycle while DIR=0x1F and the edge bits are set → everything returns to its reset value on that edge. No edge is captured after release.
